mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Slave end of the core's mem_req/mem_resp decoupled protocol: word-addressed on-chip RAM
//  that accepts mreq beats, performs the read/write, returns one mtrans beat per request.
//  Sits behind mem_arbiter's slave side (or directly on cpu.mem_req/mem_resp) in sim/FPGA tops.
//  Responses strictly in request order; fixed pipeline latency; full backpressure support.
// PARAMETERS
//  DEPTH_WORDS      1024          RAM size in 32-bit words (power of 2, >=2)
//  BASE             'h80000000    byte address of word 0 (aligned to 4*DEPTH_WORDS)
//  LATENCY          2             cycles from request accept to response valid (>=1)
//  MAX_OUTSTANDING  4             max accepted-but-unreturned requests (>=LATENCY for full rate)
// PORTS
//  clk       in   1      clock, all state on posedge
//  rst       in   1      synchronous, active-low reset
//  mem_req   decoupled.in   mreq    request: addr[31:0], we, be[3:0], wdata[31:0]
//  mem_resp  decoupled.out  mtrans  response: data[31:0] (read data; 0 for writes)
// BEHAVIOUR
//  Reset (rst==0 at posedge): mem_req.ready=0, mem_resp.valid=0, latency pipe + resp FIFO
//   emptied, outstanding count=0. RAM contents NOT reset. Reset mid-operation drops all
//   in-flight requests; no response is ever emitted for them.
//  Accept: handshake when mem_req.valid && mem_req.ready at posedge.
//   mem_req.ready = (outstanding < MAX_OUTSTANDING), registered-state only (no comb path
//   from mem_resp.ready to mem_req.ready).
//  Counter: outstanding +1 on accept, -1 on response handshake, unchanged if both same cycle.
//  Address decode: in range iff BASE <= addr < BASE+4*DEPTH_WORDS; index=(addr-BASE)>>2;
//   addr[1:0] ignored.
//  Write (we=1): at accept edge, for each i with be[i]=1, RAM[index][8i+:8]<=wdata[8i+:8].
//   be=0 writes nothing. Out-of-range write: no effect. Response data=32'h0.
//  Read (we=0): RAM sampled at accept edge, AFTER any write accepted in an earlier cycle
//   (read-after-write to same address in next cycle returns new data). Out-of-range: 32'h0.
//  Latency: request accepted at edge T -> result enters pipe; mem_resp.valid may assert no
//   earlier than cycle T+LATENCY (after edge T+LATENCY-1 ... i.e. visible LATENCY cycles
//   after accept), if no older response is still pending.
//  Pipe: LATENCY-stage shift register of {valid,data}, always advances (never stalls).
//   Last stage pushes into resp FIFO (depth MAX_OUTSTANDING) or bypasses to output when
//   FIFO empty. Outstanding limit guarantees FIFO never overflows; overflow = assertion.
//  mem_resp.data/valid are registered; once valid=1, data held stable until handshake.
//  Back-to-back: with mem_resp.ready=1 and MAX_OUTSTANDING>=LATENCY, one req/cycle sustained.
//  Full: outstanding==MAX_OUTSTANDING -> ready=0; a resp handshake in that cycle reopens
//   ready in the NEXT cycle.
//  Empty: outstanding==0 -> mem_resp.valid=0.
// TESTING
//  1 Reset: hold rst=0 3 cycles with mem_req.valid=1 -> ready=0, resp.valid=0, no RAM write.
//  2 Write addr 'h80000010 wdata 'hCAFEBABE be 4'hF, then read same addr next cycle ->
//    read resp.data='hCAFEBABE exactly LATENCY cycles after read accept, write resp data=0.
//  3 Byte enables: word='h11223344, write wdata 'hAABBCCDD be 4'b0101 -> readback 'h11BB33DD.
//  4 Backpressure: resp.ready=0, issue 6 reads -> exactly MAX_OUTSTANDING(4) accepted, ready=0;
//    release ready -> 4 responses in issue order, then remaining 2 accepted and returned.
//  5 Out of range: read 'h7FFFFFFC and BASE+4*DEPTH_WORDS -> data 0; write there -> RAM unchanged.
//  6 Reset mid-flight: accept 3 reads, assert rst=0 one cycle -> no responses ever appear,
//    outstanding=0, next request returns correctly with LATENCY cycles.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response channel pair between a memory master and mem_responder.
// Both directions are valid/ready decoupled; the response carries read data only.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_addr, req_we, req_be, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_be, req_wdata,
        output req_ready,
        output resp_valid, resp_data,
        input  resp_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed on-chip RAM answering decoupled requests with one in-order response each,
// after a fixed latency, with a bounded number of requests in flight.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE            = 32'h8000_0000,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  mem
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   ram [DEPTH_WORDS];

    logic          req_ready_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;

    logic          accept;
    logic [32:0]   offset;
    logic          in_range;
    logic [AW-1:0] index;
    logic [31:0]   rd_data;

    logic          tail_v;
    logic [31:0]   tail_d;

    logic [31:0]   fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          bypass;

    logic          resp_valid_q;
    logic [31:0]   resp_data_q;
    logic          resp_fire;
    logic          out_load;

    logic          unused_addr_lsbs;

    assign mem.req_ready  = req_ready_q;
    assign mem.resp_valid = resp_valid_q;
    assign mem.resp_data  = resp_data_q;

    // Reset dominates so nothing can be accepted on the edge that clears the pipe.
    assign accept = mem.req_valid && req_ready_q && rst;

    // 33-bit subtraction: a borrow means the address lies below BASE.
    assign offset           = {1'b0, mem.req_addr} - {1'b0, BASE};
    assign in_range         = !offset[32] && (offset[31:AW+2] == '0);
    assign index            = offset[AW+1:2];
    assign unused_addr_lsbs = ^offset[1:0];

    always_comb begin
        rd_data = 32'h0;
        if (in_range && !mem.req_we)
            rd_data = ram[index];
    end

    always_ff @(posedge clk) begin
        if (accept && mem.req_we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (mem.req_be[i])
                    ram[index][8*i +: 8] <= mem.req_wdata[8*i +: 8];
            end
        end
    end

    // The output register is the final latency stage, so only LATENCY-1 pipe stages exist.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign tail_v = accept;
            assign tail_d = rd_data;
        end else begin : g_pipe
            logic [LATENCY-2:0] pv;
            logic [31:0]        pd [LATENCY-1];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++)
                        pv[i] <= pv[i-1];
                end
            end

            always_ff @(posedge clk) begin
                pd[0] <= rd_data;
                for (int i = 1; i < LATENCY - 1; i++)
                    pd[i] <= pd[i-1];
            end

            assign tail_v = pv[LATENCY-2];
            assign tail_d = pd[LATENCY-2];
        end
    endgenerate

    assign resp_fire  = resp_valid_q && mem.resp_ready;
    assign out_load   = !resp_valid_q || resp_fire;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_pop   = out_load && !fifo_empty;
    assign bypass     = out_load && fifo_empty && tail_v;
    assign fifo_push  = tail_v && !bypass;

    always_comb begin
        outstanding_next = outstanding;
        if (accept && !resp_fire)
            outstanding_next = outstanding + 1'b1;
        else if (!accept && resp_fire)
            outstanding_next = outstanding - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding <= '0;
            req_ready_q <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            req_ready_q <= (outstanding_next < CW'(MAX_OUTSTANDING));
        end
    end

    // Older entries always sit in the FIFO, so it is drained before the pipe tail may bypass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
        end else if (out_load) begin
            if (!fifo_empty) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= fifo_mem[rd_ptr];
            end else if (tail_v) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= tail_d;
            end else begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
            if (fifo_push && !fifo_pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (fifo_pop && !fifo_push)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= tail_d;
    end

    // The outstanding limit must keep the FIFO from ever filling past its depth.
    always_ff @(posedge clk) begin
        if (rst)
            assert (!(fifo_push && !fifo_pop && fifo_cnt == CW'(MAX_OUTSTANDING)))
                else $error("mem_responder response FIFO overflow");
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, RAW, byte enables, backpressure,
// address decode boundaries and reset with requests in flight.
module tb_mem_responder;
    localparam int          LAT  = 2;
    localparam int          MAXO = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if m();

    mem_responder #(
        .DEPTH_WORDS     (1024),
        .BASE            (BASE),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mem (m)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] rq_data [$];
    int          rq_cyc  [$];

    // Log every response handshake with the cycle in which it was visible.
    always @(posedge clk) begin
        if (rst && m.resp_valid && m.resp_ready) begin
            rq_data.push_back(m.resp_data);
            rq_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input string tag, output int acc);
        m.req_valid = 1'b1;
        m.req_addr  = a;
        m.req_we    = we;
        m.req_be    = be;
        m.req_wdata = wd;
        check({tag, "_rdy"}, 32'(m.req_ready), 32'd1);
        acc = cyc;
        tick();
    endtask

    task automatic idle();
        m.req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp, input int acc, input int lat);
        logic [31:0] d;
        int          c;
        for (int i = 0; i < 40 && rq_data.size() == 0; i++)
            tick();
        check({tag, "_avail"}, 32'(rq_data.size() != 0), 32'd1);
        if (rq_data.size() != 0) begin
            d = rq_data.pop_front();
            c = rq_cyc.pop_front();
            check(tag, d, exp);
            if (lat >= 0)
                check({tag, "_lat"}, 32'(c - acc), 32'(lat));
        end
    endtask

    int a0, a1, a2, a3, a4, a5, a6, a7;
    int idx;
    int n_before;
    logic was_ready;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m.req_valid  = 1'b0;
        m.req_addr   = 32'h0;
        m.req_we     = 1'b0;
        m.req_be     = 4'h0;
        m.req_wdata  = 32'h0;
        m.resp_ready = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset held with a write pending: nothing may be accepted or written.
        put(BASE + 32'h20, 1'b1, 4'hF, 32'h1234_5678, "t1_pre", a0);
        idle();
        expect_resp("t1_pre_resp", 32'h0, a0, -1);
        rst = 1'b0;
        m.req_valid = 1'b1;
        m.req_addr  = BASE + 32'h20;
        m.req_we    = 1'b1;
        m.req_be    = 4'hF;
        m.req_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_rst_ready", 32'(m.req_ready), 32'd0);
            check("t1_rst_valid", 32'(m.resp_valid), 32'd0);
        end
        m.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        put(BASE + 32'h20, 1'b0, 4'h0, 32'h0, "t1_rd", a0);
        idle();
        expect_resp("t1_nowrite", 32'h1234_5678, a0, LAT);

        // Write then read the same word on the next cycle.
        put(32'h8000_0010, 1'b1, 4'hF, 32'hCAFE_BABE, "t2_wr", a0);
        put(32'h8000_0010, 1'b0, 4'h0, 32'h0, "t2_rd", a1);
        idle();
        expect_resp("t2_wr_resp", 32'h0, a0, LAT);
        expect_resp("t2_raw", 32'hCAFE_BABE, a1, LAT);

        // Partial byte enables.
        put(BASE + 32'h40, 1'b1, 4'hF, 32'h1122_3344, "t3_init", a0);
        put(BASE + 32'h40, 1'b1, 4'b0101, 32'hAABB_CCDD, "t3_be", a1);
        put(BASE + 32'h40, 1'b1, 4'b0000, 32'hFFFF_FFFF, "t3_be0", a2);
        put(BASE + 32'h42, 1'b0, 4'h0, 32'h0, "t3_rd", a3);
        idle();
        expect_resp("t3_init_resp", 32'h0, a0, -1);
        expect_resp("t3_be_resp", 32'h0, a1, -1);
        expect_resp("t3_be0_resp", 32'h0, a2, -1);
        expect_resp("t3_merge", 32'h11BB_33DD, a3, LAT);

        // Backpressure: preload six words, then read them with the response side stalled.
        for (int i = 0; i < 6; i++)
            put(BASE + 32'h100 + 32'(4*i), 1'b1, 4'hF, 32'hB000_0000 + 32'(i), "t4_fill", a0);
        idle();
        for (int i = 0; i < 6; i++)
            expect_resp("t4_fill_resp", 32'h0, 0, -1);
        m.resp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            m.req_valid = (idx < 6);
            m.req_addr  = BASE + 32'h100 + 32'(4*idx);
            m.req_we    = 1'b0;
            was_ready   = m.req_ready;
            tick();
            if (was_ready && idx < 6) idx++;
        end
        check("t4_accepted", 32'(idx), 32'(MAXO));
        check("t4_full_ready", 32'(m.req_ready), 32'd0);
        check("t4_resp_held", 32'(m.resp_valid), 32'd1);
        check("t4_resp_data", m.resp_data, 32'hB000_0000);
        check("t4_no_fire", 32'(rq_data.size()), 32'd0);
        m.resp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            m.req_valid = 1'b1;
            m.req_addr  = BASE + 32'h100 + 32'(4*idx);
            was_ready   = m.req_ready;
            tick();
            if (was_ready) idx++;
        end
        idle();
        check("t4_all_accepted", 32'(idx), 32'd6);
        for (int i = 0; i < 6; i++)
            expect_resp("t4_order", 32'hB000_0000 + 32'(i), 0, -1);

        // Address decode edges: just below BASE and one past the top must not alias.
        put(BASE, 1'b1, 4'hF, 32'h55AA_55AA, "t5_w0", a0);
        put(BASE + 32'hFFC, 1'b1, 4'hF, 32'h0F0F_0F0F, "t5_wtop", a1);
        put(BASE + 32'h1000, 1'b1, 4'hF, 32'hFFFF_FFFF, "t5_whi", a2);
        put(32'h7FFF_FFFC, 1'b1, 4'hF, 32'hFFFF_FFFF, "t5_wlo", a3);
        put(32'h7FFF_FFFC, 1'b0, 4'h0, 32'h0, "t5_rlo", a4);
        put(BASE + 32'h1000, 1'b0, 4'h0, 32'h0, "t5_rhi", a5);
        put(BASE, 1'b0, 4'h0, 32'h0, "t5_r0", a6);
        put(BASE + 32'hFFC, 1'b0, 4'h0, 32'h0, "t5_rtop", a7);
        idle();
        for (int i = 0; i < 4; i++)
            expect_resp("t5_wr_resp", 32'h0, 0, -1);
        expect_resp("t5_oor_lo", 32'h0, a4, LAT);
        expect_resp("t5_oor_hi", 32'h0, a5, LAT);
        expect_resp("t5_word0", 32'h55AA_55AA, a6, LAT);
        expect_resp("t5_wordtop", 32'h0F0F_0F0F, a7, LAT);

        // Reset with three reads in flight: they must vanish.
        m.resp_ready = 1'b0;
        put(BASE, 1'b0, 4'h0, 32'h0, "t6_rd", a0);
        put(BASE + 32'h40, 1'b0, 4'h0, 32'h0, "t6_rd", a1);
        put(BASE + 32'hFFC, 1'b0, 4'h0, 32'h0, "t6_rd", a2);
        idle();
        tick();
        check("t6_pending", 32'(m.resp_valid), 32'd1);
        rst = 1'b0;
        tick();
        check("t6_rst_valid", 32'(m.resp_valid), 32'd0);
        check("t6_rst_ready", 32'(m.req_ready), 32'd0);
        rst = 1'b1;
        m.resp_ready = 1'b1;
        n_before = rq_data.size();
        repeat (10) tick();
        check("t6_no_resp", 32'(rq_data.size()), 32'(n_before));
        check("t6_ready", 32'(m.req_ready), 32'd1);
        put(32'h8000_0010, 1'b0, 4'h0, 32'h0, "t6_after", a3);
        idle();
        expect_resp("t6_after_resp", 32'hCAFE_BABE, a3, LAT);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
